// File: rtl/sram_arbiter.sv
// ============================================================================
// Module  : sram_arbiter
// Brief   : Single-port SRAM arbiter for read requests, ADC pixel FIFO and
//           SPI upload, with frame-aligned freeze control.
//           Optional SPI buffer enabled by macro SRAM_ARB_SPI_FIFO_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_arbiter #(
    parameter int X_RES          = 800,
    parameter int Y_RES          = 600,
    parameter int COORD_W        = 11,
    parameter int ADDR_X_W       = 10,
    parameter int ADDR_Y_W       = 10,
    parameter int DATA_W         = 16,
    parameter int MEM_W          = 18,
    parameter int READ_LATENCY   = 3,
    parameter int SPI_FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          frozen,
    input  logic                          spi_valid,
    output logic                          spi_ready,
    input  logic [DATA_W-1:0]             spi_pixel,
    input  logic [COORD_W-1:0]            spi_x,
    input  logic [COORD_W-1:0]            spi_y,
    input  logic [2*COORD_W+DATA_W-1:0]   adc_pixel_data,
    input  logic                          adc_pixel_ready,
    output logic                          adc_pixel_read,
    input  logic                          request_active,
    input  logic [COORD_W-1:0]            request_x,
    input  logic [COORD_W-1:0]            request_y,
    output logic [DATA_W-1:0]             request_data,
    output logic                          request_ready,
    output logic                          mem_we,
    output logic [ADDR_X_W+ADDR_Y_W-1:0]  mem_addr,
    output logic [MEM_W-1:0]              mem_wdata,
    input  logic [MEM_W-1:0]              mem_rdata,
    output logic [1:0]                    freeze_state
);

    localparam logic [COORD_W-1:0] c_X_RES = COORD_W'(X_RES);
    localparam logic [COORD_W-1:0] c_Y_RES = COORD_W'(Y_RES);

    typedef enum logic [1:0] {
        LIVE        = 2'd0,
        FREEZE_PEND = 2'd1,
        FROZEN      = 2'd2,
        THAW_PEND   = 2'd3
    } state_t;

    state_t r_state, w_state_nxt;

    logic                  w_req_inb;
    logic [COORD_W-1:0]    w_adc_x, w_adc_y;
    logic [DATA_W-1:0]     w_adc_d;
    logic                  w_adc_avail, w_serve_adc, w_frame_pop, w_adc_wr_ok;
    logic                  w_spi_have, w_serve_spi;
    logic [COORD_W-1:0]    w_spi_x, w_spi_y;
    logic [DATA_W-1:0]     w_spi_d;
    logic                  w_wr_en;
    logic [COORD_W-1:0]    w_wr_x, w_wr_y;
    logic [DATA_W-1:0]     w_wr_d;
    logic [READ_LATENCY-1:0] r_rd_vld, r_rd_oob;

    assign w_req_inb = request_active && (request_x < c_X_RES) && (request_y < c_Y_RES);
    assign {w_adc_x, w_adc_y, w_adc_d} = adc_pixel_data;

    // The ADC FIFO head only advances after the pop strobe, so skip that cycle.
    assign w_adc_avail = adc_pixel_ready && !adc_pixel_read;
    assign w_serve_adc = !w_req_inb && w_adc_avail;
    assign w_serve_spi = !w_req_inb && !w_adc_avail && w_spi_have;
    assign w_frame_pop = w_serve_adc && (w_adc_x == '0) && (w_adc_y == '0);

`ifdef SRAM_ARB_SPI_FIFO_EN
    localparam int c_PTR_W = $clog2(SPI_FIFO_DEPTH);
    localparam logic [c_PTR_W:0] c_DEPTH = (c_PTR_W+1)'(SPI_FIFO_DEPTH);

    logic [2*COORD_W+DATA_W-1:0] r_fifo [SPI_FIFO_DEPTH];
    logic [c_PTR_W-1:0]          r_wr_ptr, r_rd_ptr;
    logic [c_PTR_W:0]            r_count, w_count_nxt;
    logic                        r_spi_ready, w_push;

    assign w_push     = spi_valid && r_spi_ready;
    assign w_spi_have = (r_count != '0);
    assign spi_ready  = r_spi_ready;
    assign {w_spi_x, w_spi_y, w_spi_d} = r_fifo[r_rd_ptr];
    assign w_count_nxt = r_count + {{c_PTR_W{1'b0}}, w_push} - {{c_PTR_W{1'b0}}, w_serve_spi};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_spi_ready <= 1'b0;
        end else begin
            if (w_push)      r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_serve_spi) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count     <= w_count_nxt;
            r_spi_ready <= (w_count_nxt != c_DEPTH);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wr_ptr] <= {spi_x, spi_y, spi_pixel};
    end
`else
    assign spi_ready  = !request_active && !adc_pixel_ready;
    assign w_spi_have = spi_valid && spi_ready;
    assign w_spi_x    = spi_x;
    assign w_spi_y    = spi_y;
    assign w_spi_d    = spi_pixel;
`endif

    // Frozen level changes take precedence over a coincident frame start.
    always_comb begin
        w_state_nxt = r_state;
        w_adc_wr_ok = 1'b0;
        case (r_state)
            LIVE: begin
                w_adc_wr_ok = 1'b1;
                if (frozen) w_state_nxt = FREEZE_PEND;
            end
            FREEZE_PEND: begin
                w_adc_wr_ok = 1'b1;
                if (!frozen) begin
                    w_state_nxt = LIVE;
                end else if (w_frame_pop) begin
                    w_state_nxt = FROZEN;
                    w_adc_wr_ok = 1'b0;
                end
            end
            FROZEN: begin
                if (!frozen) w_state_nxt = THAW_PEND;
            end
            THAW_PEND: begin
                if (frozen) begin
                    w_state_nxt = FROZEN;
                end else if (w_frame_pop) begin
                    w_state_nxt = LIVE;
                    w_adc_wr_ok = 1'b1;
                end
            end
            default: w_state_nxt = LIVE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= LIVE;
        else        r_state <= w_state_nxt;
    end

    assign freeze_state = r_state;

    always_comb begin
        w_wr_en = 1'b0;
        w_wr_x  = w_spi_x;
        w_wr_y  = w_spi_y;
        w_wr_d  = w_spi_d;
        if (w_serve_adc) begin
            w_wr_en = w_adc_wr_ok && (w_adc_x < c_X_RES) && (w_adc_y < c_Y_RES);
            w_wr_x  = w_adc_x;
            w_wr_y  = w_adc_y;
            w_wr_d  = w_adc_d;
        end else if (w_serve_spi) begin
            w_wr_en = (w_spi_x < c_X_RES) && (w_spi_y < c_Y_RES);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            mem_wdata      <= '0;
            adc_pixel_read <= 1'b0;
        end else begin
            adc_pixel_read <= w_serve_adc;
            mem_we         <= w_wr_en;
            if (w_req_inb) begin
                mem_addr <= {request_x[ADDR_X_W-1:0], request_y[ADDR_Y_W-1:0]};
            end else if (w_wr_en) begin
                mem_addr  <= {w_wr_x[ADDR_X_W-1:0], w_wr_y[ADDR_Y_W-1:0]};
                mem_wdata <= MEM_W'(w_wr_d);
            end
        end
    end

    // Out-of-bounds requests travel the same pipeline and return zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_vld      <= '0;
            r_rd_oob      <= '0;
            request_ready <= 1'b0;
            request_data  <= '0;
        end else begin
            r_rd_vld[0] <= request_active;
            r_rd_oob[0] <= !w_req_inb;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_rd_vld[i] <= r_rd_vld[i-1];
                r_rd_oob[i] <= r_rd_oob[i-1];
            end
            request_ready <= r_rd_vld[READ_LATENCY-1];
            if (r_rd_vld[READ_LATENCY-1]) begin
                request_data <= r_rd_oob[READ_LATENCY-1] ? '0 : DATA_W'(mem_rdata);
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sram_arbiter.sv
// ============================================================================
// Module  : tb_sram_arbiter
// Brief   : Scoreboard bench for sram_arbiter (reads, ADC/SPI writes, freeze).
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_sram_arbiter;

    localparam int X_RES = 800, Y_RES = 600, COORD_W = 11;
    localparam int ADDR_X_W = 10, ADDR_Y_W = 10, DATA_W = 16, MEM_W = 18;
    localparam int READ_LATENCY = 3, SPI_FIFO_DEPTH = 16;
    localparam int ADDR_W = ADDR_X_W + ADDR_Y_W;
    localparam int ADC_W  = 2*COORD_W + DATA_W;

    logic                 clk = 1'b0, rst_n = 1'b0, frozen = 1'b0;
    logic                 spi_valid = 1'b0, spi_ready;
    logic [DATA_W-1:0]    spi_pixel = '0;
    logic [COORD_W-1:0]   spi_x = '0, spi_y = '0;
    logic [ADC_W-1:0]     adc_pixel_data = '0;
    logic                 adc_pixel_ready = 1'b0, adc_pixel_read;
    logic                 request_active = 1'b0;
    logic [COORD_W-1:0]   request_x = '0, request_y = '0;
    logic [DATA_W-1:0]    request_data;
    logic                 request_ready, mem_we;
    logic [ADDR_W-1:0]    mem_addr;
    logic [MEM_W-1:0]     mem_wdata, mem_rdata = '0;
    logic [1:0]           freeze_state;

    int n_checks = 0, n_fail = 0;

    logic [DATA_W-1:0]       rd_q [$];
    logic [ADDR_W+MEM_W-1:0] wr_q [$];
    logic [ADC_W-1:0]        adc_q [$];
    logic [ADDR_W-1:0]       hist [READ_LATENCY];

    sram_arbiter #(
        .X_RES(X_RES), .Y_RES(Y_RES), .COORD_W(COORD_W),
        .ADDR_X_W(ADDR_X_W), .ADDR_Y_W(ADDR_Y_W), .DATA_W(DATA_W),
        .MEM_W(MEM_W), .READ_LATENCY(READ_LATENCY), .SPI_FIFO_DEPTH(SPI_FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .frozen(frozen),
        .spi_valid(spi_valid), .spi_ready(spi_ready), .spi_pixel(spi_pixel),
        .spi_x(spi_x), .spi_y(spi_y),
        .adc_pixel_data(adc_pixel_data), .adc_pixel_ready(adc_pixel_ready),
        .adc_pixel_read(adc_pixel_read),
        .request_active(request_active), .request_x(request_x), .request_y(request_y),
        .request_data(request_data), .request_ready(request_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .freeze_state(freeze_state)
    );

    always #5 clk = ~clk;

    function automatic logic [ADDR_W-1:0] addr_of(input int x, input int y);
        logic [COORD_W-1:0] xx, yy;
        xx = COORD_W'(x);
        yy = COORD_W'(y);
        return {xx[ADDR_X_W-1:0], yy[ADDR_Y_W-1:0]};
    endfunction

    function automatic logic [MEM_W-1:0] sram_word(input logic [ADDR_W-1:0] a);
        if (a == 20'h02814) return 18'h1ABCD;
        return {2'b11, a[15:0] ^ 16'hC3C3};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_req(input int x, input int y);
        logic [MEM_W-1:0] w;
        request_active = 1'b1;
        request_x = COORD_W'(x);
        request_y = COORD_W'(y);
        w = sram_word(addr_of(x, y));
        rd_q.push_back((x < X_RES && y < Y_RES) ? w[DATA_W-1:0] : '0);
        tick();
        request_active = 1'b0;
    endtask

    task automatic adc_push(input int x, input int y, input logic [DATA_W-1:0] d, input bit exp_wr);
        adc_q.push_back({COORD_W'(x), COORD_W'(y), d});
        if (exp_wr) wr_q.push_back({addr_of(x, y), MEM_W'(d)});
    endtask

    task automatic wait_adc_drain();
        int n = 0;
        tick();
        while ((adc_q.size() != 0 || adc_pixel_ready || adc_pixel_read) && n < 60) begin
            tick();
            n++;
        end
        check("adc_drain_in_time", (n < 60) ? 1 : 0, 1);
        tick();
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((rd_q.size() != 0 || wr_q.size() != 0) && n < 80) begin
            tick();
            n++;
        end
        check("scoreboard_drain_in_time", (n < 80) ? 1 : 0, 1);
    endtask

    // ADC FIFO model: head advances once per pop strobe
    always @(negedge clk) begin
        logic [ADC_W-1:0] tmp;
        if (adc_pixel_read && adc_q.size() > 0) tmp = adc_q.pop_front();
        adc_pixel_ready = (adc_q.size() > 0);
        adc_pixel_data  = (adc_q.size() > 0) ? adc_q[0] : '0;
    end

    // Monitor plus SRAM model
    always @(negedge clk) begin
        logic [DATA_W-1:0]       e_rd;
        logic [ADDR_W+MEM_W-1:0] e_wr;
        if (rst_n) begin
            if (request_ready) begin
                if (rd_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_read_response: got data 0x%0h, none expected", request_data);
                end else begin
                    e_rd = rd_q.pop_front();
                    check("read_data", {48'd0, request_data}, {48'd0, e_rd});
                end
            end
            if (mem_we) begin
                if (wr_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, none expected", mem_addr, mem_wdata);
                end else begin
                    e_wr = wr_q.pop_front();
                    check("write_addr_data", {26'd0, mem_addr, mem_wdata}, {26'd0, e_wr});
                end
            end
        end
        for (int i = READ_LATENCY-1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = mem_addr;
        mem_rdata = sram_word(hist[READ_LATENCY-1]);
    end

    initial begin
        #400000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < READ_LATENCY; i++) hist[i] = '0;
        repeat (3) tick();
        check("reset_mem_we", mem_we, 0);
        check("reset_mem_addr", mem_addr, 0);
        check("reset_request_ready", request_ready, 0);
        check("reset_adc_read", adc_pixel_read, 0);
        check("reset_freeze_state", freeze_state, 0);
        rst_n = 1'b1;
        tick();

        // Read (10,20): response strobe after edge 3 with truncated data
        read_req(10, 20);
        check("read_addr", mem_addr, 20'h02814);
        check("read_we_low", mem_we, 0);
        tick(); tick();
        check("read_not_early", request_ready, 0);
        tick();
        check("read_ready_edge3", request_ready, 1);
        check("read_data_abcd", request_data, 16'hABCD);
        wait_idle();

        // OOB request shares its slot with an ADC write
        adc_push(1, 1, 16'h1234, 1);
        read_req(800, 5);
        check("oob_slot_we", mem_we, 1);
        check("oob_slot_addr", mem_addr, 20'h00401);
        check("oob_slot_wdata", mem_wdata, 18'h01234);
        wait_idle();

        // Pipelined reads including boundaries
        read_req(799, 599);
        read_req(0, 600);
        read_req(100, 200);
        read_req(5, 5);
        wait_idle();

        // Out-of-bounds ADC pixels are popped without writes
        adc_push(800, 0, 16'h1111, 0);
        adc_push(4, 600, 16'h2222, 0);
        adc_push(0, 0, 16'h3333, 1);
        wait_adc_drain();
        check("live_state", freeze_state, 0);

        // Freeze on frame boundary
        frozen = 1'b1;
        tick();
        check("freeze_pend", freeze_state, 1);
        adc_push(5, 5, 16'h0055, 1);
        adc_push(0, 0, 16'h00AA, 0);
        adc_push(7, 7, 16'h0077, 0);
        wait_adc_drain();
        check("frozen_state", freeze_state, 2);

        // Thaw on frame boundary
        frozen = 1'b0;
        tick();
        check("thaw_pend", freeze_state, 3);
        adc_push(3, 3, 16'h0033, 0);
        adc_push(0, 0, 16'h0F0F, 1);
        wait_adc_drain();
        check("thawed_live", freeze_state, 0);
        wait_idle();

        // Level drop coincides with frame start: level wins, pixel written
        frozen = 1'b1;
        tick();
        adc_push(0, 0, 16'h4444, 1);
        frozen = 1'b0;
        wait_adc_drain();
        check("level_wins_state", freeze_state, 0);
        wait_idle();

`ifdef SRAM_ARB_SPI_FIFO_EN
        check("fifo_ready_idle", spi_ready, 1);
        for (int i = 0; i < 16; i++) begin
            request_active = 1'b1;
            request_x = COORD_W'(i);
            request_y = COORD_W'(100);
            begin
                logic [MEM_W-1:0] w;
                w = sram_word(addr_of(i, 100));
                rd_q.push_back(w[DATA_W-1:0]);
            end
            spi_valid = 1'b1;
            spi_x = COORD_W'(i + 1);
            spi_y = COORD_W'(2);
            spi_pixel = DATA_W'(16'h0100 + i);
            wr_q.push_back({addr_of(i + 1, 2), MEM_W'(16'h0100 + i)});
            tick();
        end
        spi_valid = 1'b0;
        check("fifo_full_ready_low", spi_ready, 0);
        request_active = 1'b0;
        wait_idle();
        tick();
        check("fifo_drained_ready", spi_ready, 1);
`else
        check("spi_ready_idle", spi_ready, 1);
        request_active = 1'b1;
        request_x = COORD_W'(900);
        request_y = COORD_W'(900);
        rd_q.push_back('0);
        #1;
        check("spi_ready_blocked_by_req", spi_ready, 0);
        tick();
        request_active = 1'b0;
        spi_valid = 1'b1;
        spi_x = COORD_W'(2);
        spi_y = COORD_W'(3);
        spi_pixel = 16'hBEEF;
        wr_q.push_back({20'h00803, 18'h0BEEF});
        tick();
        spi_x = COORD_W'(900);
        spi_y = COORD_W'(1);
        spi_pixel = 16'h1111;
        tick();
        spi_valid = 1'b0;
        wait_idle();
`endif

        // Reset with two reads in flight
        frozen = 1'b1;
        tick();
        check("pre_reset_state", freeze_state, 1);
        read_req(10, 20);
        read_req(11, 21);
        rst_n = 1'b0;
        rd_q.delete();
        #2;
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_request_ready", request_ready, 0);
        check("rst_request_data", request_data, 0);
        check("rst_freeze_state", freeze_state, 0);
        frozen = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        repeat (READ_LATENCY + 4) tick();
        check("post_reset_state", freeze_state, 0);
        check("final_rd_queue_empty", rd_q.size(), 0);
        check("final_wr_queue_empty", wr_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
